// File: rtl/train_pkg.sv
// Shared types and default sizes for the linear-regression training sequencer.
package train_pkg;

  localparam int LENGTH_DEF       = 16;
  localparam int ADDR_WIDTH_DEF   = 12;
  localparam int MAX_FEATURES_DEF = 15;

  // Width of the word-slot index within one dataset row (slots 0..MAX_FEATURES).
  localparam int SLOT_W = $clog2(MAX_FEATURES_DEF + 1);

  typedef enum logic [2:0] {
    LOAD,
    ISSUE,
    WAIT,
    UPD,
    DONE
  } state_t;

endpackage

// File: rtl/ser_word_rx.sv
// Bit-serial to parallel word receiver: LSB first, one word every LENGTH enabled cycles.
module ser_word_rx #(
  parameter int LENGTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s,
  output logic              word_valid,
  output logic [LENGTH-1:0] word
);

  localparam int CW = $clog2(LENGTH);

  logic [LENGTH-1:0] shreg;
  logic [CW-1:0]     bit_cnt;

  // Shift in one bit per enabled cycle and hand out the word with a one-cycle valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (en) begin
        shreg <= {s, shreg[LENGTH-1:1]};
        if (bit_cnt == CW'(LENGTH - 1)) begin
          bit_cnt    <= '0;
          word_valid <= 1'b1;
          word       <= {s, shreg[LENGTH-1:1]};
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/train_sched.sv
// Training sequencer: loads the serial dataset into memory, then drives epochs of
// sample reads and weight updates until the configured epoch count is reached.
module train_sched
  import train_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int MAX_FEATURES = MAX_FEATURES_DEF,
  parameter int LENGTH       = LENGTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S,
  input  logic [3:0]            feat,
  input  logic [7:0]            epoch,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [3:0]            learn_rate,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SLOT_W-1:0]     wr_word_sel,
  output logic [LENGTH-1:0]     wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  dp_start,
  input  logic                  dp_ack,
  output logic                  epoch_end,
  input  logic                  upd_ack,
  output logic [3:0]            lr_out,
  output logic [7:0]            cur_epoch,
  output logic                  busy,
  output logic                  done_
);

  localparam int SLOT_BITS = $clog2(MAX_FEATURES + 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] row;
  logic [SLOT_BITS-1:0]  slot;
  logic [3:0]            feat_q;
  logic [7:0]            epoch_q;
  logic [ADDR_WIDTH-1:0] dp_q;
  logic [3:0]            lr_q;
  logic                  upd_seen;
  logic                  busy_q;
  logic                  done_q;
  logic                  word_valid;
  logic [LENGTH-1:0]     word;
  logic                  last_row;
  logic                  last_epoch;

  ser_word_rx #(
    .LENGTH(LENGTH)
  ) u_rx (
    .clk       (CLK),
    .rst_n     (RST),
    .en        (state == LOAD),
    .s         (S),
    .word_valid(word_valid),
    .word      (word)
  );

  assign last_row   = (row == dp_q);
  assign last_epoch = (cur_epoch == epoch_q - 8'd1);

  // Configuration is sampled continuously during reset and frozen once it is released.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      feat_q  <= feat;
      epoch_q <= epoch;
      dp_q    <= data_points;
      lr_q    <= learn_rate;
    end
  end

  // Next-state decode and the single-cycle strobes of each state.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    dp_start  = 1'b0;
    epoch_end = 1'b0;
    case (state)
      LOAD: begin
        if (word_valid && slot == '0 && last_row)
          state_nxt = (epoch_q == 8'd0) ? DONE : ISSUE;
      end
      ISSUE: begin
        rd_en     = 1'b1;
        dp_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (dp_ack)
          state_nxt = last_row ? UPD : ISSUE;
      end
      UPD: begin
        epoch_end = !upd_seen;
        if (upd_ack && upd_seen)
          state_nxt = last_epoch ? DONE : ISSUE;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State register plus row/slot/epoch bookkeeping; an ack in the strobe cycle is never seen
  // because the ISSUE cycle ignores dp_ack and the first UPD cycle ignores upd_ack.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= LOAD;
      row       <= '0;
      slot      <= SLOT_BITS'(feat);
      cur_epoch <= '0;
      upd_seen  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      upd_seen <= (state == UPD);
      busy_q   <= (state_nxt != DONE);
      done_q   <= (state_nxt == DONE);
      case (state)
        LOAD: begin
          if (word_valid) begin
            if (slot == '0) begin
              slot <= SLOT_BITS'(feat_q);
              row  <= last_row ? '0 : row + ADDR_WIDTH'(1);
            end else begin
              slot <= slot - SLOT_BITS'(1);
            end
          end
        end
        WAIT: begin
          if (dp_ack && !last_row)
            row <= row + ADDR_WIDTH'(1);
        end
        UPD: begin
          if (upd_ack && upd_seen && !last_epoch) begin
            cur_epoch <= cur_epoch + 8'd1;
            row       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en       = word_valid;
  assign wr_data     = word;
  assign wr_addr     = word_valid ? row : '0;
  assign wr_word_sel = word_valid ? SLOT_W'(slot) : '0;
  assign rd_addr     = rd_en ? row : '0;
  assign lr_out      = lr_q;
  assign busy        = busy_q;
  assign done_       = done_q;

endmodule

// File: tb/tb_train_sched.sv
// Directed self-checking bench for train_sched.
module tb_train_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        S = 1'b0;
  logic [3:0]  feat = '0;
  logic [7:0]  epoch = '0;
  logic [11:0] data_points = '0;
  logic [3:0]  learn_rate = '0;
  logic        dp_ack = 1'b0;
  logic        upd_ack = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [3:0]  wr_word_sel;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        dp_start;
  logic        epoch_end;
  logic [3:0]  lr_out;
  logic [7:0]  cur_epoch;
  logic        busy;
  logic        done_;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int dp_delay = 1;
  int upd_delay = 1;
  bit dp_hold = 1'b0;
  bit upd_hold = 1'b0;
  int dp_timer = 0;
  int upd_timer = 0;

  logic [31:0] wr_log[$];
  logic [11:0] rd_log[$];
  logic [7:0]  ee_epoch[$];
  int          ds_cyc[$];
  int          ee_cyc = 0;
  int          done_cyc = 0;
  int          upd_ack_cyc = 0;
  int          n_done_rise = 0;
  bit          prev_done = 1'b0;

  train_sched u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .S          (S),
    .feat       (feat),
    .epoch      (epoch),
    .data_points(data_points),
    .learn_rate (learn_rate),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_word_sel(wr_word_sel),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dp_start   (dp_start),
    .dp_ack     (dp_ack),
    .epoch_end  (epoch_end),
    .upd_ack    (upd_ack),
    .lr_out     (lr_out),
    .cur_epoch  (cur_epoch),
    .busy       (busy),
    .done_      (done_)
  );

  always #5 CLK = ~CLK;

  // Logs DUT strobes and plays the datapath / weight-update responders.
  always @(negedge CLK) begin
    cyc++;
    if (wr_en === 1'b1) wr_log.push_back({wr_addr, wr_word_sel, wr_data});
    if (rd_en === 1'b1) rd_log.push_back(rd_addr);
    if (dp_start === 1'b1) ds_cyc.push_back(cyc);
    if (epoch_end === 1'b1) begin
      ee_epoch.push_back(cur_epoch);
      ee_cyc = cyc;
    end
    if (done_ === 1'b1 && !prev_done) begin
      n_done_rise++;
      done_cyc = cyc;
    end
    prev_done = (done_ === 1'b1);
    if (dp_hold) dp_ack = 1'b1;
    else begin
      dp_ack = 1'b0;
      if (dp_timer > 0) begin
        dp_timer--;
        if (dp_timer == 0) dp_ack = 1'b1;
      end
      if (dp_start === 1'b1) dp_timer = dp_delay;
    end
    if (upd_hold) upd_ack = 1'b1;
    else begin
      upd_ack = 1'b0;
      if (upd_timer > 0) begin
        upd_timer--;
        if (upd_timer == 0) upd_ack = 1'b1;
      end
      if (epoch_end === 1'b1) upd_timer = upd_delay;
    end
    if (upd_ack) upd_ack_cyc = cyc;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    ee_epoch.delete();
    ds_cyc.delete();
    n_done_rise = 0;
    dp_timer = 0;
    upd_timer = 0;
    dp_hold = 1'b0;
    upd_hold = 1'b0;
    dp_delay = 1;
    upd_delay = 1;
  endtask

  task automatic do_reset(input logic [3:0] f, input logic [7:0] e, input logic [11:0] d,
                          input logic [3:0] lr);
    RST = 1'b0;
    feat = f;
    epoch = e;
    data_points = d;
    learn_rate = lr;
    S = 1'b0;
    repeat (3) tick();
    clear_logs();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      S = w[i];
      tick();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_ !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (done_ !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_timeout: done_=%b after %0d cycles, expected 1", name, done_, n);
    end
  endtask

  task automatic test_reset();
    do_reset(4'd3, 8'd2, 12'd4, 4'hA);
    total++;
    if ({wr_en, wr_addr, wr_word_sel, wr_data, rd_en, rd_addr, dp_start, epoch_end,
         cur_epoch, done_, busy} !== 58'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: wr_en=%b wr_addr=%h sel=%h data=%h rd_en=%b rd_addr=%h dp_start=%b epoch_end=%b cur_epoch=%h done_=%b busy=%b, all expected 0",
               wr_en, wr_addr, wr_word_sel, wr_data, rd_en, rd_addr, dp_start, epoch_end,
               cur_epoch, done_, busy);
    end
    total++;
    if (lr_out !== 4'hA) begin
      bad++;
      $display("[TB] FAIL reset_lr_out: got %h expected a", lr_out);
    end
    RST = 1'b1;
    S = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_after_release: got %b expected 1", busy);
    end
  endtask

  task automatic test_load_epoch0();
    logic [31:0] exp_wr[4];
    exp_wr[0] = {12'd0, 4'd1, 16'h1234};
    exp_wr[1] = {12'd0, 4'd0, 16'h0001};
    exp_wr[2] = {12'd1, 4'd1, 16'hABCD};
    exp_wr[3] = {12'd1, 4'd0, 16'h0002};
    do_reset(4'd1, 8'd0, 12'd1, 4'd3);
    RST = 1'b1;
    send_word(16'h1234);
    total++;
    if ({wr_en, wr_addr, wr_word_sel, wr_data} !== {1'b1, exp_wr[0]}) begin
      bad++;
      $display("[TB] FAIL first_write_latency: got en=%b %h expected en=1 %h",
               wr_en, {wr_addr, wr_word_sel, wr_data}, exp_wr[0]);
    end
    send_word(16'h0001);
    send_word(16'hABCD);
    send_word(16'h0002);
    tick();
    total++;
    if ({done_, busy} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL load_done_timing: done_=%b busy=%b expected done_=1 busy=0", done_, busy);
    end
    repeat (4) tick();
    total++;
    if (wr_log.size() != 4) begin
      bad++;
      $display("[TB] FAIL load_write_count: got %0d expected 4", wr_log.size());
    end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      total++;
      if (wr_log[i] !== exp_wr[i]) begin
        bad++;
        $display("[TB] FAIL load_write_%0d: got %h expected %h", i, wr_log[i], exp_wr[i]);
      end
    end
    total++;
    if (rd_log.size() != 0 || done_ !== 1'b1) begin
      bad++;
      $display("[TB] FAIL load_no_reads: reads=%0d done_=%b expected 0 reads done_=1",
               rd_log.size(), done_);
    end
  endtask

  task automatic test_epochs();
    do_reset(4'd0, 8'd3, 12'd2, 4'd5);
    dp_delay = 1;
    upd_delay = 2;
    RST = 1'b1;
    send_word(16'h0011);
    send_word(16'h0022);
    send_word(16'h0033);
    wait_done("epochs", 500);
    tick();
    total++;
    if (wr_log.size() != 3) begin
      bad++;
      $display("[TB] FAIL epochs_write_count: got %0d expected 3", wr_log.size());
    end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      total++;
      if (wr_log[i] !== {12'(i), 4'd0, 16'(16'h0011 * (i + 1))}) begin
        bad++;
        $display("[TB] FAIL epochs_write_%0d: got %h expected %h", i, wr_log[i],
                 {12'(i), 4'd0, 16'(16'h0011 * (i + 1))});
      end
    end
    total++;
    if (rd_log.size() != 9) begin
      bad++;
      $display("[TB] FAIL epochs_read_count: got %0d expected 9", rd_log.size());
    end
    for (int i = 0; i < rd_log.size(); i++) begin
      total++;
      if (rd_log[i] !== 12'(i % 3)) begin
        bad++;
        $display("[TB] FAIL epochs_rd_addr_%0d: got %0d expected %0d", i, rd_log[i], i % 3);
      end
    end
    total++;
    if (ee_epoch.size() != 3) begin
      bad++;
      $display("[TB] FAIL epochs_epoch_end_count: got %0d expected 3", ee_epoch.size());
    end
    for (int i = 0; i < ee_epoch.size(); i++) begin
      total++;
      if (ee_epoch[i] !== 8'(i)) begin
        bad++;
        $display("[TB] FAIL epochs_cur_epoch_%0d: got %0d expected %0d", i, ee_epoch[i], i);
      end
    end
    total++;
    if (done_cyc - upd_ack_cyc != 1) begin
      bad++;
      $display("[TB] FAIL epochs_done_latency: got %0d cycles expected 1", done_cyc - upd_ack_cyc);
    end
    total++;
    if ({cur_epoch, lr_out} !== {8'd2, 4'd5}) begin
      bad++;
      $display("[TB] FAIL epochs_final_regs: cur_epoch=%0d lr_out=%0d expected 2 and 5",
               cur_epoch, lr_out);
    end
  endtask

  task automatic test_ack_held();
    do_reset(4'd0, 8'd1, 12'd3, 4'd0);
    dp_hold = 1'b1;
    upd_hold = 1'b1;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) send_word(16'(16'hF00 + i));
    wait_done("held", 300);
    tick();
    total++;
    if (rd_log.size() != 4) begin
      bad++;
      $display("[TB] FAIL held_read_count: got %0d expected 4", rd_log.size());
    end
    for (int i = 0; i < rd_log.size(); i++) begin
      total++;
      if (rd_log[i] !== 12'(i)) begin
        bad++;
        $display("[TB] FAIL held_rd_addr_%0d: got %0d expected %0d", i, rd_log[i], i);
      end
    end
    for (int i = 1; i < ds_cyc.size(); i++) begin
      total++;
      if (ds_cyc[i] - ds_cyc[i-1] != 2) begin
        bad++;
        $display("[TB] FAIL held_issue_spacing_%0d: got %0d cycles expected 2", i,
                 ds_cyc[i] - ds_cyc[i-1]);
      end
    end
    total++;
    if (ee_epoch.size() != 1 || done_cyc - ee_cyc != 2) begin
      bad++;
      $display("[TB] FAIL held_update: epoch_end=%0d done_after=%0d expected 1 and 2",
               ee_epoch.size(), done_cyc - ee_cyc);
    end
    dp_hold = 1'b0;
    upd_hold = 1'b0;
  endtask

  task automatic test_reset_midop();
    int n = 0;
    do_reset(4'd1, 8'd3, 12'd7, 4'd2);
    dp_delay = 3;
    upd_delay = 1;
    RST = 1'b1;
    for (int i = 0; i < 16; i++) send_word(16'(16'h0100 + i));
    while (!(dp_start === 1'b1 && rd_addr === 12'd5 && cur_epoch === 8'd1) && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (!(dp_start === 1'b1 && rd_addr === 12'd5 && cur_epoch === 8'd1)) begin
      bad++;
      $display("[TB] FAIL midop_reach_row5: rd_addr=%0d cur_epoch=%0d expected 5 and 1",
               rd_addr, cur_epoch);
    end
    tick();
    RST = 1'b0;
    feat = 4'd2;
    epoch = 8'd0;
    data_points = 12'd0;
    tick();
    total++;
    if ({wr_en, wr_addr, wr_word_sel, wr_data, rd_en, rd_addr, dp_start, epoch_end,
         cur_epoch, done_, busy} !== 58'd0) begin
      bad++;
      $display("[TB] FAIL midop_reset_outputs: rd_en=%b dp_start=%b cur_epoch=%0d done_=%b busy=%b, all expected 0",
               rd_en, dp_start, cur_epoch, done_, busy);
    end
    tick();
    clear_logs();
    RST = 1'b1;
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    send_word(16'hCCCC);
    tick();
    total++;
    if (wr_log.size() != 3) begin
      bad++;
      $display("[TB] FAIL reload_write_count: got %0d expected 3", wr_log.size());
    end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      total++;
      if (wr_log[i] !== {12'd0, 4'(2 - i), 16'(16'hAAAA + 16'h1111 * i)}) begin
        bad++;
        $display("[TB] FAIL reload_write_%0d: got %h expected %h", i, wr_log[i],
                 {12'd0, 4'(2 - i), 16'(16'hAAAA + 16'h1111 * i)});
      end
    end
    total++;
    if (done_ !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reload_done: got %b expected 1", done_);
    end
  endtask

  task automatic test_long();
    int k = 0;
    do_reset(4'd5, 8'd4, 12'd9, 4'd7);
    RST = 1'b1;
    feat = 4'd3;
    epoch = 8'd1;
    data_points = 12'd2;
    learn_rate = 4'd1;
    for (int r = 0; r < 10; r++)
      for (int s = 5; s >= 0; s--) send_word(16'(r * 256 + s * 16 + 5));
    wait_done("long", 2000);
    repeat (5) tick();
    total++;
    if (wr_log.size() != 60) begin
      bad++;
      $display("[TB] FAIL long_write_count: got %0d expected 60", wr_log.size());
    end
    for (int r = 0; r < 10; r++)
      for (int s = 5; s >= 0; s--) begin
        if (k < wr_log.size()) begin
          total++;
          if (wr_log[k] !== {12'(r), 4'(s), 16'(r * 256 + s * 16 + 5)}) begin
            bad++;
            $display("[TB] FAIL long_write_%0d: got %h expected %h", k, wr_log[k],
                     {12'(r), 4'(s), 16'(r * 256 + s * 16 + 5)});
          end
        end
        k++;
      end
    total++;
    if (ds_cyc.size() != 40 || rd_log.size() != 40) begin
      bad++;
      $display("[TB] FAIL long_dp_start_count: got %0d starts %0d reads expected 40",
               ds_cyc.size(), rd_log.size());
    end
    for (int i = 0; i < rd_log.size(); i++) begin
      total++;
      if (rd_log[i] !== 12'(i % 10)) begin
        bad++;
        $display("[TB] FAIL long_rd_addr_%0d: got %0d expected %0d", i, rd_log[i], i % 10);
      end
    end
    total++;
    if (ee_epoch.size() != 4) begin
      bad++;
      $display("[TB] FAIL long_epoch_end_count: got %0d expected 4", ee_epoch.size());
    end
    total++;
    if (n_done_rise != 1 || done_ !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL long_done_once: rises=%0d done_=%b busy=%b expected 1 1 0",
               n_done_rise, done_, busy);
    end
    total++;
    if ({lr_out, cur_epoch} !== {4'd7, 8'd3}) begin
      bad++;
      $display("[TB] FAIL long_latched_cfg: lr_out=%0d cur_epoch=%0d expected 7 and 3",
               lr_out, cur_epoch);
    end
  endtask

  initial begin
    test_reset();
    test_load_epoch0();
    test_epochs();
    test_ack_held();
    test_reset_midop();
    test_long();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
